// File: rtl/sdram_arb_pkg.sv
// Shared types and sizes for the SDRAM arbiter and its grant picker.
package sdram_arb_pkg;
    localparam int NPORTS = 3;
    localparam int AW     = 24;
    localparam int DW     = 32;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_ACCESS = 1'b1
    } arb_state_t;

    typedef logic [1:0] port_idx_t;

    // Port after p, wrapping at NPORTS.
    function automatic port_idx_t next_port(input port_idx_t p);
        return (p == port_idx_t'(NPORTS - 1)) ? port_idx_t'(0) : port_idx_t'(p + 2'd1);
    endfunction
endpackage

// File: rtl/sdram_arb_picker.sv
// Combinational grant pick: first pending port found searching upward from i_ptr.
// With i_ptr tied to 0 this is plain fixed priority 0 > 1 > 2.
module sdram_arb_picker
    import sdram_arb_pkg::*;
(
    input  logic [NPORTS-1:0] i_pending,
    input  port_idx_t         i_ptr,
    output port_idx_t         o_grant,
    output logic              o_valid
);
    always_comb begin
        port_idx_t v_idx;
        o_valid = 1'b0;
        o_grant = '0;
        v_idx   = i_ptr;
        for (int k = 0; k < NPORTS; k++) begin
            if (!o_valid && i_pending[v_idx]) begin
                o_valid = 1'b1;
                o_grant = v_idx;
            end
            v_idx = next_port(v_idx);
        end
    end
endmodule

// File: rtl/sdram_arbiter.sv
// Three-port arbiter in front of the single SDRAM controller: latches word requests,
// serves them one at a time and routes read data back. SDRAM_ARB_RR_EN selects round-robin.
module sdram_arbiter
    import sdram_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NPORTS-1:0]    req_start,
    input  logic [NPORTS-1:0]    req_we,
    input  logic [NPORTS*AW-1:0] req_addr,
    input  logic [NPORTS*DW-1:0] req_d,
    output logic [NPORTS-1:0]    req_busy,
    output logic [NPORTS-1:0]    req_done,
    output logic [NPORTS*DW-1:0] req_q,
    input  logic                 ctrl_init_done,
    input  logic                 ctrl_busy,
    input  logic                 ctrl_q_ready,
    input  logic [DW-1:0]        ctrl_q,
    output logic                 ctrl_start,
    output logic                 ctrl_we,
    output logic [AW-1:0]        ctrl_addr,
    output logic [DW-1:0]        ctrl_d
);
    arb_state_t          r_state;
    arb_state_t          w_state_next;
    logic                w_grant_fire;
    logic                w_complete;

    logic [NPORTS-1:0]   r_pending;
    logic [NPORTS-1:0]   w_accept;
    logic [NPORTS-1:0]   w_clear;
    logic                r_lat_we   [NPORTS];
    logic [AW-1:0]       r_lat_addr [NPORTS];
    logic [DW-1:0]       r_lat_d    [NPORTS];

    port_idx_t           r_grant;
    port_idx_t           w_pick;
    logic                w_pick_valid;
    port_idx_t           w_ptr;

    logic                r_ctrl_start;
    logic                r_ctrl_we;
    logic [AW-1:0]       r_ctrl_addr;
    logic [DW-1:0]       r_ctrl_d;
    logic [NPORTS-1:0]   r_req_done;
    logic [NPORTS*DW-1:0] r_req_q;

    // Completion is taken from ctrl_q_ready alone; ctrl_busy is informational only.
    logic                w_unused_ctrl_busy;
    assign w_unused_ctrl_busy = ctrl_busy;

    sdram_arb_picker u_picker (
        .i_pending (r_pending),
        .i_ptr     (w_ptr),
        .o_grant   (w_pick),
        .o_valid   (w_pick_valid)
    );

`ifdef SDRAM_ARB_RR_EN
    port_idx_t r_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_grant_fire) begin
            r_ptr <= next_port(w_pick);
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant_fire = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (ctrl_init_done && w_pick_valid) begin
                    w_grant_fire = 1'b1;
                    w_state_next = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                if (ctrl_q_ready) begin
                    w_complete   = 1'b1;
                    w_state_next = ARB_IDLE;
                end
            end
            default: w_state_next = ARB_IDLE;
        endcase
    end

    // Accept only while idle-per-port; clear only the granted port, which is pending.
    assign w_accept = req_start & ~r_pending;
    assign w_clear  = {NPORTS{w_complete}} & (NPORTS'(1) << r_grant);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending  <= '0;
            r_req_done <= '0;
        end else begin
            r_pending  <= (r_pending | w_accept) & ~w_clear;
            r_req_done <= w_clear;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NPORTS; i++) begin
            if (w_accept[i]) begin
                r_lat_we[i]   <= req_we[i];
                r_lat_addr[i] <= req_addr[i*AW +: AW];
                r_lat_d[i]    <= req_d[i*DW +: DW];
            end
        end
    end

    // Command registers stay frozen for the whole access so a refresh-delayed start is retried intact.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl_start <= 1'b0;
            r_ctrl_we    <= 1'b0;
            r_ctrl_addr  <= '0;
            r_ctrl_d     <= '0;
            r_grant      <= '0;
        end else if (w_grant_fire) begin
            r_ctrl_start <= 1'b1;
            r_ctrl_we    <= r_lat_we[w_pick];
            r_ctrl_addr  <= r_lat_addr[w_pick];
            r_ctrl_d     <= r_lat_d[w_pick];
            r_grant      <= w_pick;
        end else if (w_complete) begin
            r_ctrl_start <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_q <= '0;
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                if (w_complete && !r_ctrl_we && (r_grant == port_idx_t'(i))) begin
                    r_req_q[i*DW +: DW] <= ctrl_q;
                end
            end
        end
    end

    assign req_busy   = r_pending;
    assign req_done   = r_req_done;
    assign req_q      = r_req_q;
    assign ctrl_start = r_ctrl_start;
    assign ctrl_we    = r_ctrl_we;
    assign ctrl_addr  = r_ctrl_addr;
    assign ctrl_d     = r_ctrl_d;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: random and directed requests, a behavioural
// SDRAM controller model, and a monitor checking grants, commands and completions.
`timescale 1ns/1ps
module tb_sdram_arbiter;
    import sdram_arb_pkg::*;

`ifdef SDRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NPORTS-1:0]    req_start, req_we, req_busy, req_done;
    logic [NPORTS*AW-1:0] req_addr;
    logic [NPORTS*DW-1:0] req_d, req_q;
    logic                 ctrl_init_done, ctrl_busy, ctrl_q_ready;
    logic [DW-1:0]        ctrl_q;
    logic                 ctrl_start, ctrl_we;
    logic [AW-1:0]        ctrl_addr;
    logic [DW-1:0]        ctrl_d;

    sdram_arbiter dut (
        .clk(clk), .reset(reset),
        .req_start(req_start), .req_we(req_we), .req_addr(req_addr), .req_d(req_d),
        .req_busy(req_busy), .req_done(req_done), .req_q(req_q),
        .ctrl_init_done(ctrl_init_done), .ctrl_busy(ctrl_busy),
        .ctrl_q_ready(ctrl_q_ready), .ctrl_q(ctrl_q),
        .ctrl_start(ctrl_start), .ctrl_we(ctrl_we), .ctrl_addr(ctrl_addr), .ctrl_d(ctrl_d)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] d;
        logic [DW-1:0] q;
    } txn_t;

    txn_t          exp_q [NPORTS][$];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] cm_mem  [logic [AW-1:0]];
    int            set_cnt  [NPORTS] = '{default: 0};
    int            done_cnt [NPORTS] = '{default: 0};
    logic [DW-1:0] last_read [NPORTS] = '{default: '0};
    int            grant_log [$];
    int            episodes    = 0;
    int            done_pulses = 0;
    int            last_g      = NPORTS - 1;
    int            cm_lat      = 0;
    int            n_checks    = 0;
    int            n_errors    = 0;

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return (a == 24'h000123) ? 32'hDEADBEEF : {8'hA5, a};
    endfunction

    // First pending port found scanning upward from s (wrapping).
    function automatic int pick(input logic [NPORTS-1:0] p, input int s);
        for (int k = 0; k < NPORTS; k++)
            if (p[(s + k) % NPORTS]) return (s + k) % NPORTS;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present a start on port i; the model only records it when the port is free.
    task automatic post(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        req_start[i]         = 1'b1;
        req_we[i]            = we;
        req_addr[i*AW +: AW] = a;
        req_d[i*DW +: DW]    = d;
        if (set_cnt[i] == done_cnt[i]) begin
            t.we = we; t.addr = a; t.d = d; t.q = '0;
            if (we) ref_mem[a] = d;
            else    t.q = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
            exp_q[i].push_back(t);
            set_cnt[i]++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        req_start = '0;
    endtask

    task automatic wait_idle(input int maxc);
        int c = 0;
        while ((req_busy != '0 || ctrl_start) && c < maxc) begin
            @(negedge clk);
            c++;
        end
        chk("idle_timeout", 64'(c >= maxc), 64'(0));
        repeat (2) @(negedge clk);
    endtask

    // Controller model: completes each start after a latency, optionally after a refresh stall.
    initial begin
        int  cnt;
        bit  active;
        ctrl_q_ready = 1'b0; ctrl_q = '0; ctrl_busy = 1'b0;
        active = 1'b0; cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                ctrl_q_ready = 1'b0; ctrl_busy = 1'b0; active = 1'b0;
                continue;
            end
            if (ctrl_q_ready) begin
                ctrl_q_ready = 1'b0; ctrl_busy = 1'b0;
                continue;
            end
            if (!active && ctrl_start) begin
                active = 1'b1; ctrl_busy = 1'b1;
                if (cm_lat > 0) cnt = cm_lat;
                else cnt = (($urandom_range(0, 3) == 0) ? 8 : 0) + int'($urandom_range(1, 5));
            end
            if (active) begin
                cnt--;
                if (cnt <= 0) begin
                    if (ctrl_we) begin
                        cm_mem[ctrl_addr] = ctrl_d;
                        ctrl_q = $urandom;
                    end else begin
                        ctrl_q = cm_mem.exists(ctrl_addr) ? cm_mem[ctrl_addr] : dflt(ctrl_addr);
                    end
                    ctrl_q_ready = 1'b1;
                    active = 1'b0;
                end
            end
        end
    end

    // Monitor: pops expected completions and checks every new controller command.
    initial begin
        txn_t              t;
        int                g;
        logic [NPORTS-1:0] pend;
        logic [NPORTS-1:0] snap = '0;
        logic              prev_start = 1'b0;
        logic              p_we = 1'b0;
        logic [AW-1:0]     p_addr = '0;
        logic [DW-1:0]     p_d = '0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                for (int i = 0; i < NPORTS; i++) begin
                    done_cnt[i] = set_cnt[i];
                    exp_q[i].delete();
                    last_read[i] = '0;
                end
                snap = '0; prev_start = 1'b0; last_g = NPORTS - 1;
                continue;
            end
            for (int i = 0; i < NPORTS; i++) begin
                if (req_done[i]) begin
                    done_pulses++;
                    if (exp_q[i].size() == 0) begin
                        chk("spurious_done", 64'(req_done[i]), 64'(0));
                    end else begin
                        t = exp_q[i].pop_front();
                        done_cnt[i]++;
                        if (!t.we) last_read[i] = t.q;
                        chk("req_q", 64'(req_q[i*DW +: DW]), 64'(last_read[i]));
                    end
                end
            end
            for (int i = 0; i < NPORTS; i++) pend[i] = (set_cnt[i] != done_cnt[i]);
            chk("req_busy", 64'(req_busy), 64'(pend));
            if (ctrl_start && !prev_start) begin
                episodes++;
                g = pick(snap, RR ? (last_g + 1) % NPORTS : 0);
                if (g < 0 || exp_q[g].size() == 0) begin
                    chk("grant_none", 64'(ctrl_start), 64'(0));
                end else begin
                    grant_log.push_back(g);
                    last_g = g;
                    chk("ctrl_addr", 64'(ctrl_addr), 64'(exp_q[g][0].addr));
                    chk("ctrl_we", 64'(ctrl_we), 64'(exp_q[g][0].we));
                    if (exp_q[g][0].we) chk("ctrl_d", 64'(ctrl_d), 64'(exp_q[g][0].d));
                end
            end else if (ctrl_start && prev_start) begin
                chk("hold_cmd", {7'd0, ctrl_we, ctrl_addr, ctrl_d}, {7'd0, p_we, p_addr, p_d});
            end
            prev_start = ctrl_start; p_we = ctrl_we; p_addr = ctrl_addr; p_d = ctrl_d;
            snap = pend;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ep0, gl0, dp0;
        int exp_ord [3];
        req_start = '0; req_we = '0; req_addr = '0; req_d = '0;
        ctrl_init_done = 1'b1; reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_outputs", 64'({req_busy, req_done, ctrl_start, ctrl_we}), 64'(0));
        chk("rst_cmd", {8'd0, ctrl_addr, ctrl_d}, 64'(0));
        chk("rst_req_q", 64'(req_q[63:0]), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        // Single read on port 1 with 6-cycle completion.
        cm_lat = 6; ep0 = episodes; dp0 = done_pulses;
        post(1, 1'b0, 24'h000123, 32'h0);
        tick();
        @(negedge clk);
        chk("t1_start", 64'(ctrl_start), 64'(1));
        chk("t1_addr", 64'(ctrl_addr), 64'(24'h000123));
        chk("t1_we", 64'(ctrl_we), 64'(0));
        wait_idle(100);
        chk("t1_done_once", 64'(done_pulses - dp0), 64'(1));
        chk("t1_episodes", 64'(episodes - ep0), 64'(1));
        chk("t1_req_q", 64'(req_q[1*DW +: DW]), 64'(32'hDEADBEEF));
        chk("t1_busy", 64'(req_busy[1]), 64'(0));

        // Port 0 alone, then all three ports in the same cycle.
        cm_lat = 2;
        post(0, 1'b0, 24'h000004, 32'h0);
        tick();
        wait_idle(100);
        ep0 = episodes; gl0 = grant_log.size();
        post(0, 1'b0, 24'h000001, 32'h0);
        post(1, 1'b0, 24'h400002, 32'h0);
        post(2, 1'b0, 24'h800003, 32'h0);
        tick();
        wait_idle(200);
        if (RR) exp_ord = '{1, 2, 0};
        else    exp_ord = '{0, 1, 2};
        chk("t2_episodes", 64'(episodes - ep0), 64'(3));
        for (int k = 0; k < 3; k++)
            chk("t2_order", 64'((grant_log.size() > gl0 + k) ? grant_log[gl0 + k] : -1), 64'(exp_ord[k]));

        // Refresh stall: start must stay high until the late completion.
        cm_lat = 14; ep0 = episodes;
        post(0, 1'b0, 24'h000005, 32'h0);
        tick();
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            chk("t3_start_held", 64'(ctrl_start), 64'(1));
        end
        wait_idle(100);
        chk("t3_episodes", 64'(episodes - ep0), 64'(1));

        // Port 2: read, write, read back; a write must not touch req_q.
        cm_lat = 3;
        post(2, 1'b0, 24'h800010, 32'h0);
        tick();
        wait_idle(100);
        post(2, 1'b1, 24'h800040, 32'h12345678);
        tick();
        @(negedge clk);
        chk("t4_ctrl_d", 64'(ctrl_d), 64'(32'h12345678));
        chk("t4_ctrl_we", 64'(ctrl_we), 64'(1));
        wait_idle(100);
        chk("t4_req_q_kept", 64'(req_q[2*DW +: DW]), 64'(32'hA5800010));
        post(2, 1'b0, 24'h800040, 32'h0);
        tick();
        wait_idle(100);
        chk("t4_readback", 64'(req_q[2*DW +: DW]), 64'(32'h12345678));

        // Controller not initialised: no grant until init_done rises.
        ctrl_init_done = 1'b0; cm_lat = 2;
        post(0, 1'b0, 24'h000006, 32'h0);
        tick();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk("t5_no_start", 64'(ctrl_start), 64'(0));
        end
        ctrl_init_done = 1'b1;
        @(posedge clk); #1;
        chk("t5_start", 64'(ctrl_start), 64'(1));
        @(negedge clk);
        wait_idle(100);

        // Reset in the middle of an access with two ports pending.
        cm_lat = 20;
        post(0, 1'b0, 24'h000007, 32'h0);
        post(1, 1'b0, 24'h400007, 32'h0);
        tick();
        repeat (3) @(negedge clk);
        chk("t6_in_access", 64'({ctrl_start, req_busy}), 64'(4'b1011));
        #2 reset = 1'b1;
        #1;
        chk("t6_async_rst", 64'({req_busy, req_done, ctrl_start, ctrl_we}), 64'(0));
        chk("t6_rst_cmd", {8'd0, ctrl_addr, ctrl_d}, 64'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        dp0 = done_pulses;
        repeat (30) @(negedge clk);
        chk("t6_no_done", 64'(done_pulses - dp0), 64'(0));
        chk("t6_idle", 64'({req_busy, ctrl_start}), 64'(0));

        // Random traffic with per-port address regions.
        cm_lat = 0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NPORTS; i++)
                if ($urandom_range(0, 3) == 0)
                    post(i, 1'($urandom_range(0, 1)), {port_idx_t'(i), 18'd0, 4'($urandom_range(0, 15))}, $urandom);
            tick();
        end
        wait_idle(500);
        for (int i = 0; i < NPORTS; i++)
            chk("final_drain", 64'(exp_q[i].size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Three-port arbiter sharing the single SDRAM controller between requesters (port 0 CPU, port 1 GPU/VRAM fetch, port 2 DMA/bootloader). Each port issues single 32-bit word reads/writes with a start/busy/done handshake. The arbiter latches requests, grants one at a time, holds the controller's start until the access completes, and routes read data back. It sits between the memory unit and the SDRAM controller, in the controller's posedge clock domain.

## Interface
Parameters:
- `NPORTS`, 3: number of requesters (fixed by package; not overridable).
- `AW`, 24: word address width.
- `DW`, 32: data width.

Ports:
- `clk`  in  1  system clock; all arbiter logic is on the posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_start`  in  NPORTS  per-port request strobe; sampled only while that port's `req_busy` is low.
- `req_we`  in  NPORTS  per-port write enable, sampled with `req_start`.
- `req_addr`  in  NPORTS*AW  packed word addresses; port i at `[i*AW +: AW]`.
- `req_d`  in  NPORTS*DW  packed write data.
- `req_busy`  out  NPORTS  port has a latched, uncompleted request.
- `req_done`  out  NPORTS  one-cycle completion pulse.
- `req_q`  out  NPORTS*DW  per-port read data; held until that port's next read completes.
- `ctrl_init_done`  in  1  controller initialisation complete.
- `ctrl_busy`  in  1  controller busy (informational; not used for completion).
- `ctrl_q_ready`  in  1  controller completion pulse, one cycle; read or write.
- `ctrl_q`  in  DW  controller read data, valid with `ctrl_q_ready`.
- `ctrl_start`  out  1  request to controller.
- `ctrl_we`, `ctrl_addr`, `ctrl_d`  out  1/AW/DW  command to controller.

## Operation
- Per port: pending flag plus latched we/addr/d. Rising edge with `req_start[i]` and `!pending[i]` sets pending and captures inputs. Start while pending is ignored.
- `req_busy = pending`. It is a direct register.
- States: IDLE and ACCESS.
- IDLE: if `ctrl_init_done` and any pending, pick grant `g`. Copy latched we/addr/d of `g` to the `ctrl_*` registers, set `ctrl_start`=1, and go to ACCESS. Otherwise `ctrl_start`=0.
- ACCESS: `ctrl_start` and `ctrl_*` held constant. The controller ignores start while refreshing, so start stays asserted until completion.
- On `ctrl_q_ready` in ACCESS:
  - clear `ctrl_start`;
  - clear `pending[g]`;
  - pulse `req_done[g]`;
  - if `ctrl_we`=0, load `req_q[g]` from `ctrl_q`;
  - return to IDLE.
- `ctrl_q_ready` in IDLE is ignored.
- Default grant policy is fixed priority: port 0 > port 1 > port 2.
- A port's new start accepted on the same edge as its `req_done` pulse is allowed, because pending is cleared by that edge. That request is latched from the next edge.
- If `ctrl_init_done` falls, the arbiter issues no new grant. An access in progress is still waited on.

## Timing
- Reset values:
  - state IDLE; `pending`=0, so `req_busy`=0;
  - `req_done`=0, `req_q`=0;
  - `ctrl_start`=0, `ctrl_we`=0, `ctrl_addr`=0, `ctrl_d`=0;
  - round-robin pointer=0.
- Latency:
  - `req_start` sampled at edge E0 → `req_busy` high after E0;
  - `ctrl_start` high after E1, when the arbiter is idle and the port wins;
  - `req_done` high the cycle after the edge sampling `ctrl_q_ready`.
- Simultaneous starts on several ports are all latched on the same edge, then served in policy order, one access at a time.
- Reset mid-access aborts immediately. All pending requests are lost and no `req_done` is issued.

## Configuration
- `SDRAM_ARB_RR_EN` defined: round-robin grant. Search starts at the port after the last granted (modulo 3). The pointer updates at grant.
- Not defined: fixed priority 0 > 1 > 2. No pointer register exists.

## Structure
- Package `sdram_arb_pkg`: `NPORTS`, `AW`, `DW`, state enum (`ARB_IDLE`, `ARB_ACCESS`), port index type (2 bits).
- Sub-module `sdram_arb_picker`: combinational pick of a grant index and a valid flag from the pending vector and the pointer. The pointer input is tied to 0 when `SDRAM_ARB_RR_EN` is undefined.

## Test plan
- Single read, port 1 at addr 0x000123. The controller model returns 0xDEADBEEF with `ctrl_q_ready` 6 cycles after start:
  - `ctrl_addr`=0x000123, `ctrl_we`=0;
  - `req_done[1]` pulses once;
  - `req_q[1]`=0xDEADBEEF;
  - `req_busy[1]` falls.
- Same-cycle starts on all three ports, fixed priority: grant order 0,1,2, with exactly three `ctrl_start` episodes. With `SDRAM_ARB_RR_EN` and pointer after port 0 last granted, the order is 1,2,0.
- Refresh collision: the model is busy refreshing for 8 cycles before accepting. `ctrl_start` stays high throughout and exactly one access occurs.
- Write of 0x12345678 on port 2:
  - `ctrl_d`=0x12345678, `ctrl_we`=1;
  - `req_q[2]` unchanged after `req_done[2]`.
- `ctrl_init_done`=0 for 40 cycles with port 0 pending: no `ctrl_start` until init is done, then the access is issued one edge later.
- Reset asserted while in ACCESS with two ports pending: outputs return to their reset values asynchronously, and no `req_done` pulses afterwards.
